// File: rtl/conv_stream_if.sv
// Output stream of the convolution output streamer: one feature-map element
// per handshake, tagged with its grid coordinates and an end-of-frame flag.
//
// Handshake: the master raises out_valid and keeps out_data/out_row/out_col/
// out_last stable until a cycle where out_valid && out_ready are both high at
// the rising clock edge; that edge is the transfer. out_valid never depends
// on out_ready, and the slave may drive out_ready at any time.
interface conv_stream_if #(
  parameter int OUT_WIDTH = 8,
  parameter int RC_W      = 1
);
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [RC_W-1:0]      out_row;
  logic [RC_W-1:0]      out_col;
  logic                 out_last;

  modport master (
    output out_data, out_valid, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/conv_output_streamer.sv
// Captures a full OUT_SIZE x OUT_SIZE output feature map from the systolic
// array on p_load and streams it row-major over conv_stream_if, saturating
// each element to OUT_WIDTH. Loads arriving mid-frame are dropped and counted
// so the array never has to stall; a load on the final transfer chains the
// next frame with no bubble.
module conv_output_streamer #(
  parameter int  N          = 3,
  parameter int  M          = 2,
  parameter int  data_width = 1,
  parameter int  OUT_WIDTH  = 8,
  localparam int IN_W       = 2 * data_width + 1,
  localparam int OUT_SIZE   = N - M + 1,
  localparam int RC_W       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] p_in [0:OUT_SIZE-1][0:OUT_SIZE-1],
  input  logic            p_load,
  conv_stream_if.master   out_if,
  output logic            busy,
  output logic [7:0]      drop_count,
  output logic            dbg_state
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [RC_W-1:0] LAST_RC = RC_W'(OUT_SIZE - 1);

  state_t          state_q, state_d;
  logic [RC_W-1:0] row_q, row_d;
  logic [RC_W-1:0] col_q, col_d;
  logic [7:0]      drop_q, drop_d;
  logic [IN_W-1:0] buf_q [0:OUT_SIZE-1][0:OUT_SIZE-1];
  logic [IN_W-1:0] buf_d [0:OUT_SIZE-1][0:OUT_SIZE-1];

  logic                 streaming;
  logic                 xfer;
  logic                 is_last;
  logic [IN_W-1:0]      elem;
  logic [OUT_WIDTH-1:0] elem_sat;

  assign streaming = (state_q == STREAM);
  assign xfer      = streaming && out_if.out_ready;
  assign is_last   = (row_q == LAST_RC) && (col_q == LAST_RC);
  assign elem      = buf_q[row_q][col_q];

  // Clamp unsigned partial sums that do not fit the output width.
  generate
    if (OUT_WIDTH >= IN_W) begin : g_zext
      assign elem_sat = OUT_WIDTH'(elem);
    end else begin : g_clamp
      localparam logic [IN_W-1:0] MAX_V = {{(IN_W-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};
      assign elem_sat = (elem > MAX_V) ? {OUT_WIDTH{1'b1}} : elem[OUT_WIDTH-1:0];
    end
  endgenerate

  // Next-state: frame capture, row-major index advance, drop counting.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    drop_d  = drop_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (p_load) begin
          buf_d   = p_in;
          row_d   = '0;
          col_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer && is_last) begin
          // A load on the final transfer chains the next frame, not a drop.
          row_d = '0;
          col_d = '0;
          if (p_load) buf_d = p_in;
          else        state_d = IDLE;
        end else begin
          if (xfer) begin
            if (col_q == LAST_RC) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
          if (p_load && (drop_q != 8'hFF)) drop_d = drop_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      drop_q  <= '0;
      for (int r = 0; r < OUT_SIZE; r++)
        for (int c = 0; c < OUT_SIZE; c++)
          buf_q[r][c] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drop_q  <= drop_d;
      buf_q   <= buf_d;
    end
  end

  // Outputs decode registered state only; everything reads 0 while idle.
  assign out_if.out_valid = streaming;
  assign out_if.out_data  = streaming ? elem_sat : '0;
  assign out_if.out_row   = streaming ? row_q : '0;
  assign out_if.out_col   = streaming ? col_q : '0;
  assign out_if.out_last  = streaming && is_last;
  assign busy             = streaming;
  assign drop_count       = drop_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_conv_output_streamer.sv
// Directed bench for conv_output_streamer (N=3, M=2, data_width=1, so a
// 2x2 frame of 3-bit elements). A second instance with OUT_WIDTH=2 covers
// saturation. Inputs change and outputs are sampled 1ns after rising edges.
module tb_conv_output_streamer;

  logic clk;
  logic reset;

  logic [2:0] p_in   [0:1][0:1];
  logic       p_load;
  logic       busy;
  logic [7:0] drop_count;
  logic       dbg_state;

  logic [2:0] p_in_s [0:1][0:1];
  logic       p_load_s;
  logic       busy_s;
  logic [7:0] drop_count_s;
  logic       dbg_state_s;

  int total;
  int bad;

  conv_stream_if #(.OUT_WIDTH(8), .RC_W(1)) s_if ();
  conv_stream_if #(.OUT_WIDTH(2), .RC_W(1)) s2_if ();

  conv_output_streamer #(.N(3), .M(2), .data_width(1), .OUT_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .p_in       (p_in),
    .p_load     (p_load),
    .out_if     (s_if.master),
    .busy       (busy),
    .drop_count (drop_count),
    .dbg_state  (dbg_state)
  );

  conv_output_streamer #(.N(3), .M(2), .data_width(1), .OUT_WIDTH(2)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .p_in       (p_in_s),
    .p_load     (p_load_s),
    .out_if     (s2_if.master),
    .busy       (busy_s),
    .drop_count (drop_count_s),
    .dbg_state  (dbg_state_s)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks the full element view of the main instance.
  task automatic chk_elem(input string tag, input int data, input int row, input int col, input int last);
    chk({tag, ".valid"}, {31'd0, s_if.out_valid}, 32'd1);
    chk({tag, ".data"},  {24'd0, s_if.out_data}, 32'(data));
    chk({tag, ".row"},   {31'd0, s_if.out_row}, 32'(row));
    chk({tag, ".col"},   {31'd0, s_if.out_col}, 32'(col));
    chk({tag, ".last"},  {31'd0, s_if.out_last}, 32'(last));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, {31'd0, s_if.out_valid}, 32'd0);
    chk({tag, ".busy"},  {31'd0, busy}, 32'd0);
    chk({tag, ".data"},  {24'd0, s_if.out_data}, 32'd0);
    chk({tag, ".row"},   {31'd0, s_if.out_row}, 32'd0);
    chk({tag, ".col"},   {31'd0, s_if.out_col}, 32'd0);
    chk({tag, ".last"},  {31'd0, s_if.out_last}, 32'd0);
  endtask

  task automatic set_frame(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] d);
    p_in[0][0] = a;
    p_in[0][1] = b;
    p_in[1][0] = c;
    p_in[1][1] = d;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    p_load       = 1'b0;
    p_load_s     = 1'b0;
    s_if.out_ready  = 1'b0;
    s2_if.out_ready = 1'b1;
    set_frame(3'd0, 3'd0, 3'd0, 3'd0);
    p_in_s[0][0] = 3'd7;
    p_in_s[0][1] = 3'd3;
    p_in_s[1][0] = 3'd4;
    p_in_s[1][1] = 3'd0;

    // Reset state
    tick();
    tick();
    chk_idle("rst0");
    chk("rst0.drop", {24'd0, drop_count}, 32'd0);

    // Asynchronous reset mid-cycle while an element is presented
    reset = 1'b1;
    tick();
    set_frame(3'd1, 3'd2, 3'd3, 3'd4);
    p_load = 1'b1;
    tick();
    p_load = 1'b0;
    chk_elem("pre_async", 1, 0, 0, 0);
    #3;
    reset = 1'b0;
    #1;
    chk_idle("async_rst");
    tick();
    reset = 1'b1;
    tick();
    chk_idle("post_rst");

    // Basic frame, ready held high
    s_if.out_ready = 1'b1;
    set_frame(3'd1, 3'd2, 3'd3, 3'd4);
    p_load = 1'b1;
    tick();
    p_load = 1'b0;
    chk_elem("basic0", 1, 0, 0, 0);
    chk("basic0.busy", {31'd0, busy}, 32'd1);
    tick();
    chk_elem("basic1", 2, 0, 1, 0);
    tick();
    chk_elem("basic2", 3, 1, 0, 0);
    tick();
    chk_elem("basic3", 4, 1, 1, 1);
    tick();
    chk_idle("basic_end");

    // Ready ignored while idle
    tick();
    chk_idle("idle_ready");

    // Backpressure at idx 1
    p_load = 1'b1;
    tick();
    p_load = 1'b0;
    chk_elem("bp0", 1, 0, 0, 0);
    tick();
    chk_elem("bp1", 2, 0, 1, 0);
    s_if.out_ready = 1'b0;
    tick();
    chk_elem("bp_hold1", 2, 0, 1, 0);
    tick();
    chk_elem("bp_hold2", 2, 0, 1, 0);
    tick();
    chk_elem("bp_hold3", 2, 0, 1, 0);
    s_if.out_ready = 1'b1;
    tick();
    chk_elem("bp2", 3, 1, 0, 0);
    tick();
    chk_elem("bp3", 4, 1, 1, 1);
    tick();
    chk_idle("bp_end");

    // Drops: frame A streams, frame B offered at idx 1 and idx 2
    set_frame(3'd5, 3'd5, 3'd5, 3'd5);
    p_load = 1'b1;
    tick();
    p_load = 1'b0;
    chk_elem("dropA0", 5, 0, 0, 0);
    tick();
    chk_elem("dropA1", 5, 0, 1, 0);
    set_frame(3'd7, 3'd6, 3'd2, 3'd1);
    p_load = 1'b1;
    tick();
    chk_elem("dropA2", 5, 1, 0, 0);
    chk("drop_after1", {24'd0, drop_count}, 32'd1);
    tick();
    p_load = 1'b0;
    chk_elem("dropA3", 5, 1, 1, 1);
    chk("drop_after2", {24'd0, drop_count}, 32'd2);
    tick();
    chk_idle("drop_end");
    chk("drop_end.count", {24'd0, drop_count}, 32'd2);

    // Back-to-back frames with load on the final transfer
    set_frame(3'd1, 3'd2, 3'd3, 3'd4);
    p_load = 1'b1;
    tick();
    p_load = 1'b0;
    chk_elem("b2b_a0", 1, 0, 0, 0);
    tick();
    tick();
    tick();
    chk_elem("b2b_a3", 4, 1, 1, 1);
    set_frame(3'd6, 3'd7, 3'd0, 3'd1);
    p_load = 1'b1;
    tick();
    p_load = 1'b0;
    chk_elem("b2b_b0", 6, 0, 0, 0);
    chk("b2b.drop", {24'd0, drop_count}, 32'd2);
    tick();
    chk_elem("b2b_b1", 7, 0, 1, 0);
    tick();
    chk_elem("b2b_b2", 0, 1, 0, 0);
    tick();
    chk_elem("b2b_b3", 1, 1, 1, 1);
    tick();
    chk_idle("b2b_end");

    // Reset mid-stream at idx 2, then reload
    set_frame(3'd1, 3'd2, 3'd3, 3'd4);
    p_load = 1'b1;
    tick();
    p_load = 1'b0;
    tick();
    tick();
    chk_elem("mid2", 3, 1, 0, 0);
    reset = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst.drop", {24'd0, drop_count}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk_idle("mid_release");
    set_frame(3'd1, 3'd1, 3'd1, 3'd1);
    p_load = 1'b1;
    tick();
    p_load = 1'b0;
    chk_elem("reload0", 1, 0, 0, 0);
    chk("reload.drop", {24'd0, drop_count}, 32'd0);
    tick();
    chk_elem("reload1", 1, 0, 1, 0);
    tick();
    chk_elem("reload2", 1, 1, 0, 0);
    tick();
    chk_elem("reload3", 1, 1, 1, 1);
    tick();
    chk_idle("reload_end");

    // Saturation to 2 bits: {{7,3},{4,0}} -> 3,3,3,0
    chk("sat_idle.valid", {31'd0, s2_if.out_valid}, 32'd0);
    p_load_s = 1'b1;
    tick();
    p_load_s = 1'b0;
    chk("sat0.valid", {31'd0, s2_if.out_valid}, 32'd1);
    chk("sat0.data", {30'd0, s2_if.out_data}, 32'd3);
    tick();
    chk("sat1.data", {30'd0, s2_if.out_data}, 32'd3);
    tick();
    chk("sat2.data", {30'd0, s2_if.out_data}, 32'd3);
    chk("sat2.row", {31'd0, s2_if.out_row}, 32'd1);
    tick();
    chk("sat3.data", {30'd0, s2_if.out_data}, 32'd0);
    chk("sat3.last", {31'd0, s2_if.out_last}, 32'd1);
    tick();
    chk("sat_end.valid", {31'd0, s2_if.out_valid}, 32'd0);
    chk("sat_end.busy", {31'd0, busy_s}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_output_streamer.md
# conv_output_streamer

Downstream stage of the convolution systolic array. On a load strobe it captures the array's full output feature map (OUT_SIZE x OUT_SIZE partial sums) into an internal frame buffer. It then streams the elements out one per handshake, in row-major order, over a valid/ready interface, with per-element row/column tags, a last-element flag and width saturation. Load strobes that arrive while a frame is still streaming are dropped and counted, so the array never stalls.

## Interface
- `N`, 3, input feature-map dimension (matches array).
- `M`, 2, filter dimension (matches array).
- `data_width`, 1, array operand width; input element width IN_W = 2*data_width+1.
- `OUT_WIDTH`, 8, width of streamed element.
- Derived: OUT_SIZE = N-M+1; FRAME = OUT_SIZE*OUT_SIZE; IDX_W = max(1,$clog2(FRAME)); RC_W = max(1,$clog2(OUT_SIZE)).

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `p_in`  in  [IN_W-1:0] x [0:OUT_SIZE-1][0:OUT_SIZE-1]  array output grid.
- `p_load`  in  1  single-cycle strobe: p_in holds a complete frame this cycle.
- `out_data`  out  OUT_WIDTH  current element, saturated.
- `out_valid`  out  1  out_data/out_row/out_col/out_last are valid.
- `out_ready`  in  1  consumer accepts the element this cycle.
- `out_row`, `out_col`  out  RC_W each  grid coordinates of the current element.
- `out_last`  out  1  current element is index FRAME-1.
- `busy`  out  1  a frame is held or streaming (state STREAM).
- `drop_count`  out  8  dropped-frame count, saturates at 255.

## Operation
- FSM states:
  - IDLE: out_valid=0, busy=0.
  - STREAM: out_valid=1, busy=1.
- IDLE with p_load=1:
  - capture all of p_in into the buffer;
  - idx <- 0;
  - go to STREAM.
- STREAM transfer = out_valid & out_ready.
  - On a transfer with idx < FRAME-1: idx <- idx+1.
- On a transfer with idx == FRAME-1:
  - if p_load=1 in the same cycle: capture the new frame, idx <- 0, stay in STREAM (back-to-back frame, not a drop);
  - else go to IDLE.
- p_load=1 in STREAM in any other cycle:
  - frame ignored; buffer unchanged;
  - drop_count <- min(drop_count+1, 255).
- Element mapping: element at idx = buffer[idx / OUT_SIZE][idx % OUT_SIZE]; out_row = idx / OUT_SIZE; out_col = idx % OUT_SIZE.
- Saturation:
  - OUT_WIDTH >= IN_W: zero-extend.
  - Otherwise: values > 2^OUT_WIDTH-1 output as 2^OUT_WIDTH-1.
  - Values are unsigned.
- While out_valid=1 and out_ready=0, out_data/row/col/last are held stable. The buffer does not change until the final transfer.
- out_ready is ignored in IDLE.

## Timing
- Reset (reset=0, asynchronous):
  - state IDLE, idx 0, buffer 0, drop_count 0;
  - out_valid 0, out_data 0, out_row 0, out_col 0, out_last 0, busy 0.
- Reset mid-stream aborts the frame. No element is re-presented after reset release.
- Load latency: p_load sampled at edge k; out_valid=1 with element 0 from edge k (visible in cycle k+1).
- Throughput: one element per cycle with out_ready held high. A FRAME-element frame occupies FRAME cycles. A back-to-back load on the last transfer gives zero bubble.
- All outputs are registered or decoded from registered state only. No combinational path from out_ready or p_load to any output.
- FRAME=1 (N==M): the first element is also last; out_last=1 whenever out_valid=1.

## Test plan
- Reset check: N=3, M=2, data_width=1 (OUT_SIZE=2, IN_W=3).
  - Assert reset=0 mid-cycle -> all outputs 0 immediately.
  - Release and load p_in={{1,2},{3,4}} with out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, (row,col)=(0,0),(0,1),(1,0),(1,1); out_last only with 4; then out_valid=0, busy=0.
- Backpressure: same frame, out_ready low for 3 cycles at idx 1 -> out_data held at 2, row 0, col 1; after ready rises, 3 then 4 follow with no loss or duplicate.
- Drop: load frame A={{5,5},{5,5}}, then pulse p_load with frame B at idx 1 and idx 2 -> A streams unchanged; drop_count=2; B never appears.
- Back-to-back: p_load with frame {{6,7},{0,1}} in the same cycle as the last transfer of the previous frame -> next cycle shows out_valid=1, out_data 6, idx 0, drop_count unchanged.
- Saturation: OUT_WIDTH=2, p_in={{7,3},{4,0}} -> out_data 3,3,3,0.
- Reset mid-stream: reset=0 at idx 2, then reload {{1,1},{1,1}} -> stream restarts at (0,0); drop_count=0.
